// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: default widths and the
// funct3/funct7 encodings the issue logic and its bench need.
package alu_issue_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned IMM_W      = 12;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'b000_0000;
  localparam logic [6:0] F7_SUB  = 7'b010_0000;

endpackage

// File: rtl/alu_issue_opsel.sv
// Per-operand source select: in-flight ALU result, held result, or regfile.
// Ports:
//   rs        source register address
//   rf_rdata  regfile read data for rs
//   x_valid/x_rd/alu_rslt  op currently inside the ALU and its result
//   h_valid/h_rd/h_data    result parked in the hold buffer
//   opd_c     selected operand (combinational)
// FWD_EN=0 collapses the mux to regfile-only (the issue stage then stalls).
module alu_issue_opsel #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_rdata,
  input  logic              x_valid,
  input  logic [REG_AW-1:0] x_rd,
  input  logic [XLEN-1:0]   alu_rslt,
  input  logic              h_valid,
  input  logic [REG_AW-1:0] h_rd,
  input  logic [XLEN-1:0]   h_data,
  output logic [XLEN-1:0]   opd_c
);

  // x0 is never a forwarding target; the in-flight op is younger than the held one
  always_comb begin
    opd_c = rf_rdata;
    if (rs == '0) begin
      opd_c = '0;
    end else if (FWD_EN && x_valid && (x_rd == rs)) begin
      opd_c = alu_rslt;
    end else if (FWD_EN && h_valid && (h_rd == rs)) begin
      opd_c = h_data;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of a 1-cycle ALU: reads sources, drives ALU fields,
// tracks the op in flight and hands the result to writeback with a
// 1-entry hold buffer absorbing writeback backpressure.
// Optional feature macro: ALU_ISSUE_FWD_EN (operand forwarding from the
// in-flight / held result; undefined -> stall on RAW hazards instead).
// Ports:
//   clk, rst (async, active-low)
//   in_*        decoded op + valid/ready handshake
//   rf_raddr*/rf_rdata*  async regfile read
//   alu_*       ALU fields out, alu_rslt back one cycle after issue
//   wb_*        result to writeback, valid/ready handshake
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_imm,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic [2:0]        alu_funct3,
  output logic [6:0]        alu_funct7,
  output logic [XLEN-1:0]   alu_opd1,
  output logic [XLEN-1:0]   alu_opd2,
  input  logic [XLEN-1:0]   alu_rslt,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data
);

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              x_valid;
  logic [REG_AW-1:0] x_rd;
  logic              h_valid;
  logic [REG_AW-1:0] h_rd;
  logic [XLEN-1:0]   h_data;

  logic              fire;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [XLEN-1:0]   opd1_c;
  logic [XLEN-1:0]   opd2_c;
  logic [XLEN-1:0]   imm_sext;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  // RAW hazard against either pending result (only matters without forwarding)
  assign rs1_busy = (in_rs1 != '0) &&
                    ((x_valid && (x_rd == in_rs1)) || (h_valid && (h_rd == in_rs1)));
  assign rs2_busy = !in_is_imm && (in_rs2 != '0) &&
                    ((x_valid && (x_rd == in_rs2)) || (h_valid && (h_rd == in_rs2)));

  // Blocking while h_valid guarantees x_valid and h_valid are never both set
  assign in_ready = !h_valid && !(x_valid && !wb_ready) &&
                    (FWD_EN || !(rs1_busy || rs2_busy));
  assign fire     = in_valid && in_ready;

  alu_issue_opsel #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_opsel1 (
    .rs       (in_rs1),
    .rf_rdata (rf_rdata1),
    .x_valid  (x_valid),
    .x_rd     (x_rd),
    .alu_rslt (alu_rslt),
    .h_valid  (h_valid),
    .h_rd     (h_rd),
    .h_data   (h_data),
    .opd_c    (opd1_c)
  );

  alu_issue_opsel #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_opsel2 (
    .rs       (in_rs2),
    .rf_rdata (rf_rdata2),
    .x_valid  (x_valid),
    .x_rd     (x_rd),
    .alu_rslt (alu_rslt),
    .h_valid  (h_valid),
    .h_rd     (h_rd),
    .h_data   (h_data),
    .opd_c    (opd2_c)
  );

  assign imm_sext   = XLEN'(signed'(in_imm));
  assign alu_funct3 = in_funct3;
  assign alu_opd1   = opd1_c;
  assign alu_opd2   = in_is_imm ? imm_sext : opd2_c;

  // I-type only carries funct7 for shifts (imm[11:5]); ADDI must never turn into SUB
  always_comb begin
    alu_funct7 = F7_ZERO;
    if (!in_is_imm) begin
      alu_funct7 = in_funct7;
    end else if (in_funct3 == F3_SR) begin
      alu_funct7 = in_imm[11:5];
    end
  end

  // Hold buffer has priority; idle outputs read as zero
  assign wb_valid = h_valid || x_valid;
  assign wb_rd    = h_valid ? h_rd   : (x_valid ? x_rd     : '0);
  assign wb_data  = h_valid ? h_data : (x_valid ? alu_rslt : '0);

  // In-flight tracking and hold capture/drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_valid <= 1'b0;
      x_rd    <= '0;
      h_valid <= 1'b0;
      h_rd    <= '0;
      h_data  <= '0;
    end else begin
      x_valid <= fire;
      if (fire) begin
        x_rd <= in_rd;
      end
      if (x_valid && !wb_ready && !h_valid) begin
        h_valid <= 1'b1;
        h_rd    <= x_rd;
        h_data  <= alu_rslt;
      end else if (h_valid && wb_ready) begin
        h_valid <= 1'b0;
      end
    end
  end

endmodule
